// File: rtl/router_fsm_n_pkg.sv
// Shared types and constants for the router input-side write-path controller.
package router_pkg;

    localparam int ROUTER_NUM_CH_MAX = 256;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        LOAD_PARITY        = 4'd4,
        FIFO_FULL_STATE    = 4'd5,
        LOAD_AFTER_FULL    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_e;

    // Bit order: {detect_add, lfd_state, ld_state, laf_state, full_state,
    //             write_enb_reg, rst_int_reg, busy, drop_state}
    localparam logic [8:0] OUT_DECODE_ADDRESS     = 9'b1_0000_0000;
    localparam logic [8:0] OUT_LOAD_FIRST_DATA    = 9'b0_1000_0010;
    localparam logic [8:0] OUT_WAIT_TILL_EMPTY    = 9'b0_0000_0010;
    localparam logic [8:0] OUT_LOAD_DATA          = 9'b0_0100_1000;
    localparam logic [8:0] OUT_LOAD_PARITY        = 9'b0_0000_1010;
    localparam logic [8:0] OUT_FIFO_FULL_STATE    = 9'b0_0001_0010;
    localparam logic [8:0] OUT_LOAD_AFTER_FULL    = 9'b0_0010_1010;
    localparam logic [8:0] OUT_CHECK_PARITY_ERROR = 9'b0_0000_0110;
    localparam logic [8:0] OUT_DROP_PACKET        = 9'b0_0000_0011;

    function automatic logic [8:0] decode_outputs(input state_e s);
        logic [8:0] v;
        v = '0;
        case (s)
            DECODE_ADDRESS:     v = OUT_DECODE_ADDRESS;
            LOAD_FIRST_DATA:    v = OUT_LOAD_FIRST_DATA;
            WAIT_TILL_EMPTY:    v = OUT_WAIT_TILL_EMPTY;
            LOAD_DATA:          v = OUT_LOAD_DATA;
            LOAD_PARITY:        v = OUT_LOAD_PARITY;
            FIFO_FULL_STATE:    v = OUT_FIFO_FULL_STATE;
            LOAD_AFTER_FULL:    v = OUT_LOAD_AFTER_FULL;
            CHECK_PARITY_ERROR: v = OUT_CHECK_PARITY_ERROR;
            DROP_PACKET:        v = OUT_DROP_PACKET;
            default:            v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/router_fsm_n_if.sv
// Handshake bundle between the input register block / channel FIFOs and the write-path FSM.
interface router_fsm_n_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              low_pkt_valid;
    logic              parity_done;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_state;
    logic [ADDR_W-1:0] addr_q;

    modport master (
        output pkt_valid, data_in, fifo_full, low_pkt_valid, parity_done,
               fifo_empty, soft_reset,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_state, addr_q
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, low_pkt_valid, parity_done,
               fifo_empty, soft_reset,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_state, addr_q
    );
endinterface

// File: rtl/router_fsm_n_sat_cnt.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module router_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/router_fsm_n.sv
// Write-path controller for an NUM_CH-channel router; packets to absent channels are swallowed.
// Optional drop counter output enabled by defining ROUTER_FSM_DROP_CNT_EN.
//
// state              | meaning
// DECODE_ADDRESS     | idle, latch header address on pkt_valid
// LOAD_FIRST_DATA    | write header byte into the selected FIFO
// WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
// LOAD_DATA          | write payload bytes
// LOAD_PARITY        | write trailing parity byte
// FIFO_FULL_STATE    | stalled on FIFO full
// LOAD_AFTER_FULL    | write the byte held during the stall
// CHECK_PARITY_ERROR | parity compare cycle
// DROP_PACKET        | consume a packet for a non-existent channel
module router_fsm_n
    import router_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
) (
    input  logic          clock,
    input  logic          resetn,
    router_fsm_n_if.slave bus
`ifdef ROUTER_FSM_DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);
    localparam int NUM_ADDR = 2 ** ADDR_W;

    if (NUM_CH < 1 || NUM_CH > NUM_ADDR || NUM_CH > ROUTER_NUM_CH_MAX) begin : g_bad_num_ch
        $error("router_fsm_n: NUM_CH out of range for ADDR_W");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_ADDR-1:0] empty_ext, soft_ext;
    logic              hdr_in_range;
    logic              addr_q_in_range;
    logic              soft_hit;
    logic [8:0]        out_vec;

    // Widen per-channel flags to the full address space so any address indexes safely.
    always_comb begin
        empty_ext = '0;
        soft_ext  = '0;
        empty_ext[NUM_CH-1:0] = bus.fifo_empty;
        soft_ext[NUM_CH-1:0]  = bus.soft_reset;
    end

    assign hdr_in_range    = int'(bus.data_in) < NUM_CH;
    assign addr_q_in_range = int'(addr_q) < NUM_CH;
    assign soft_hit        = addr_q_in_range && soft_ext[addr_q] &&
                             (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    addr_d = bus.data_in;
                    if (!hdr_in_range) begin
                        state_d = DROP_PACKET;
                    end else if (empty_ext[bus.data_in]) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_ext[addr_q]) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                if (!bus.pkt_valid) begin
                    state_d = DECODE_ADDRESS;
                end
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A read-timeout on the active channel abandons the packet in progress.
        if (soft_hit) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign out_vec = decode_outputs(state_q);
    assign {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.drop_state} = out_vec;
    assign bus.addr_q = addr_q;

`ifdef ROUTER_FSM_DROP_CNT_EN
    router_sat_cnt #(
        .WIDTH (8)
    ) u_drop_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc_i  ((state_q == DECODE_ADDRESS) && (state_d == DROP_PACKET)),
        .cnt_o  (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_router_fsm_n.sv
// Bench for router_fsm_n: NUM_CH=4 and NUM_CH=3 instances against a packet-level reference model.
module tb_router_fsm_n;
    import router_pkg::*;

    typedef enum int { M_DA, M_LFD, M_WTE, M_LD, M_LP, M_FFS, M_LAF, M_CPE, M_DROP } mstate_e;

    logic       clock = 1'b0;
    logic       rstn  = 1'b0;
    logic       pv    = 1'b0;
    logic [1:0] din   = '0;
    logic       ff    = 1'b0;
    logic       lpv   = 1'b0;
    logic       pd    = 1'b0;
    logic [3:0] fe    = '1;
    logic [3:0] sr    = '0;

    int n_chk  = 0;
    int n_fail = 0;

    mstate_e m_st[2];
    int      m_addr[2];
    int      m_cnt[2];
    int      nch[2] = '{4, 3};

    always #5 clock = ~clock;

    router_fsm_n_if #(.NUM_CH(4), .ADDR_W(2)) if_a ();
    router_fsm_n_if #(.NUM_CH(3), .ADDR_W(2)) if_b ();

    assign if_a.pkt_valid     = pv;
    assign if_a.data_in       = din;
    assign if_a.fifo_full     = ff;
    assign if_a.low_pkt_valid = lpv;
    assign if_a.parity_done   = pd;
    assign if_a.fifo_empty    = fe;
    assign if_a.soft_reset    = sr;
    assign if_b.pkt_valid     = pv;
    assign if_b.data_in       = din;
    assign if_b.fifo_full     = ff;
    assign if_b.low_pkt_valid = lpv;
    assign if_b.parity_done   = pd;
    assign if_b.fifo_empty    = fe[2:0];
    assign if_b.soft_reset    = sr[2:0];

`ifdef ROUTER_FSM_DROP_CNT_EN
    logic [7:0] drop_cnt_a, drop_cnt_b;
    router_fsm_n #(.NUM_CH(4), .ADDR_W(2)) dut_a (.clock(clock), .resetn(rstn), .bus(if_a), .drop_cnt(drop_cnt_a));
    router_fsm_n #(.NUM_CH(3), .ADDR_W(2)) dut_b (.clock(clock), .resetn(rstn), .bus(if_b), .drop_cnt(drop_cnt_b));
`else
    router_fsm_n #(.NUM_CH(4), .ADDR_W(2)) dut_a (.clock(clock), .resetn(rstn), .bus(if_a));
    router_fsm_n #(.NUM_CH(3), .ADDR_W(2)) dut_b (.clock(clock), .resetn(rstn), .bus(if_b));
`endif

    // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy, drop}
    wire [8:0] obs_a = {if_a.detect_add, if_a.lfd_state, if_a.ld_state, if_a.laf_state, if_a.full_state,
                        if_a.write_enb_reg, if_a.rst_int_reg, if_a.busy, if_a.drop_state};
    wire [8:0] obs_b = {if_b.detect_add, if_b.lfd_state, if_b.ld_state, if_b.laf_state, if_b.full_state,
                        if_b.write_enb_reg, if_b.rst_int_reg, if_b.busy, if_b.drop_state};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_flags(input mstate_e s);
        logic wen, busy;
        wen  = (s == M_LD) || (s == M_LP) || (s == M_LAF);
        busy = !((s == M_DA) || (s == M_LD));
        return {s == M_DA, s == M_LFD, s == M_LD, s == M_LAF, s == M_FFS,
                wen, s == M_CPE, busy, s == M_DROP};
    endfunction

    task automatic model_next(input int k, output mstate_e sn, output int an, output int cn);
        mstate_e s;
        int a, n;
        s  = m_st[k];
        a  = m_addr[k];
        n  = nch[k];
        sn = s;
        an = a;
        cn = m_cnt[k];
        if (!rstn) begin
            sn = M_DA;
            an = 0;
            cn = 0;
            return;
        end
        case (s)
            M_DA: if (pv) begin
                an = int'(din);
                if (int'(din) >= n) begin
                    sn = M_DROP;
                    cn = (cn < 255) ? cn + 1 : 255;
                end else begin
                    sn = fe[din] ? M_LFD : M_WTE;
                end
            end
            M_WTE:  if (fe[a]) sn = M_LFD;
            M_LFD:  sn = M_LD;
            M_LD:   if (ff) sn = M_FFS; else if (!pv) sn = M_LP;
            M_FFS:  if (!ff) sn = M_LAF;
            M_LAF:  sn = pd ? M_DA : (lpv ? M_LP : M_LD);
            M_LP:   sn = M_CPE;
            M_CPE:  sn = ff ? M_FFS : M_DA;
            M_DROP: if (!pv) sn = M_DA;
            default: sn = M_DA;
        endcase
        if (s != M_DA && s != M_DROP && a < n && sr[a]) sn = M_DA;
    endtask

    task automatic step();
        mstate_e sn[2];
        int an[2], cn[2];
        for (int k = 0; k < 2; k++) model_next(k, sn[k], an[k], cn[k]);
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_st[k]   = sn[k];
            m_addr[k] = an[k];
            m_cnt[k]  = cn[k];
        end
        chk("flags_a", obs_a, exp_flags(m_st[0]));
        chk("addr_a", if_a.addr_q, m_addr[0]);
        chk("flags_b", obs_b, exp_flags(m_st[1]));
        chk("addr_b", if_b.addr_q, m_addr[1]);
`ifdef ROUTER_FSM_DROP_CNT_EN
        chk("drop_cnt_a", drop_cnt_a, m_cnt[0]);
        chk("drop_cnt_b", drop_cnt_b, m_cnt[1]);
`endif
    endtask

    task automatic drive(input logic v, input logic [1:0] d);
        pv  = v;
        din = d;
    endtask

    initial begin
        int wen_cycles, busy_cycles, drop_cycles, wen_b;
        m_st   = '{M_DA, M_DA};
        m_addr = '{0, 0};
        m_cnt  = '{0, 0};

        rstn = 1'b0;
        step();
        step();
        chk("rst_detect_add", if_a.detect_add, 1'b1);
        chk("rst_flags_b", obs_b, 9'h100);
        rstn = 1'b1;

        // header to channel 2, three payload bytes, parity
        fe = 4'b1111;
        wen_cycles = 0;
        drive(1'b1, 2'd2); step(); wen_cycles += int'(obs_a[3]);
        chk("s1_lfd", if_a.lfd_state, 1'b1);
        step(); wen_cycles += int'(obs_a[3]);
        chk("s1_ld", if_a.ld_state, 1'b1);
        step(); wen_cycles += int'(obs_a[3]);
        step(); wen_cycles += int'(obs_a[3]);
        drive(1'b0, 2'd0); step(); wen_cycles += int'(obs_a[3]);
        step(); wen_cycles += int'(obs_a[3]);
        chk("s1_cpe", if_a.rst_int_reg, 1'b1);
        step(); wen_cycles += int'(obs_a[3]);
        chk("s1_back_da", if_a.detect_add, 1'b1);
        chk("s1_addr", if_a.addr_q, 2'd2);
        chk("s1_wen_cycles", wen_cycles, 4);

        // channel 1 busy for four cycles, then full stall and low_pkt_valid exit
        fe = 4'b1101;
        busy_cycles = 0;
        drive(1'b1, 2'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            busy_cycles += int'(obs_a[1] && !obs_a[7]);
        end
        chk("s2_wte_busy", busy_cycles, 4);
        fe = 4'b1111;
        step();
        chk("s2_lfd", if_a.lfd_state, 1'b1);
        step();
        ff = 1'b1; step();
        chk("s3_full1", if_a.full_state, 1'b1);
        step();
        chk("s3_full2", if_a.full_state, 1'b1);
        ff = 1'b0; step();
        chk("s3_laf", if_a.laf_state, 1'b1);
        lpv = 1'b1; drive(1'b0, 2'd0); step();
        chk("s3_lp", obs_a, 9'h00a);
        lpv = 1'b0; step(); step();

        // parity_done in LOAD_AFTER_FULL returns straight to decode
        drive(1'b1, 2'd0); step(); step();
        ff = 1'b1; step();
        ff = 1'b0; step();
        pd = 1'b1; step();
        chk("s3_pd_da", if_a.detect_add, 1'b1);
        pd = 1'b0; drive(1'b0, 2'd0);

        // soft reset on channel 0 while waiting; channel 1 bit ignored
        fe = 4'b1110;
        drive(1'b1, 2'd0); step();
        sr = 4'b0010; step();
        chk("sr_other_ignored", obs_a, 9'h002);
        sr = 4'b0001; step();
        chk("sr_own_da", if_a.detect_add, 1'b1);
        chk("sr_own_da_b", if_b.detect_add, 1'b1);
        sr = 4'b0000; fe = 4'b1111; drive(1'b0, 2'd0); step();

        // address 3 is absent on the 3-channel instance
        drop_cycles = 0;
        wen_b = 0;
        drive(1'b1, 2'd3);
        for (int i = 0; i < 6; i++) begin
            step();
            drop_cycles += int'(obs_b[0]);
            wen_b += int'(obs_b[3]);
        end
        drive(1'b0, 2'd0); step();
        wen_b += int'(obs_b[3]);
        chk("drop_cycles", drop_cycles, 6);
        chk("drop_no_write", wen_b, 0);
        chk("drop_back_da", if_b.detect_add, 1'b1);
        chk("drop_addr_held", if_b.addr_q, 2'd3);
`ifdef ROUTER_FSM_DROP_CNT_EN
        chk("drop_cnt_one", drop_cnt_b, 8'd1);
`endif
        step(); step();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd3); step();
            drive(1'b0, 2'd0); step();
        end
`ifdef ROUTER_FSM_DROP_CNT_EN
        chk("drop_cnt_sat", drop_cnt_b, 8'd255);
`endif

        // reset in the middle of LOAD_DATA
        rstn = 1'b0; step(); rstn = 1'b1;
        drive(1'b1, 2'd2); step(); step();
        chk("rst_mid_in_ld", if_a.ld_state, 1'b1);
        rstn = 1'b0; step();
        chk("rst_mid_flags", obs_a, 9'h100);
        chk("rst_mid_addr", if_a.addr_q, 2'd0);
        rstn = 1'b1; drive(1'b0, 2'd0);

        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 199) != 0);
            pv   = ($urandom_range(0, 3) != 0);
            din  = 2'($urandom_range(0, 3));
            ff   = ($urandom_range(0, 3) == 0);
            lpv  = ($urandom_range(0, 3) == 0);
            pd   = ($urandom_range(0, 4) == 0);
            fe   = 4'($urandom) | 4'($urandom);
            sr   = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
